branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
- Each cycle it supplies predict_pc for the PC being fetched, and trains from resolved branches in EX.
- Also generates the 2-bit `count` warm-up/recovery window that the flush unit uses to suppress flushes during reset and post-flush bubbles.
- Sits directly upstream of the flush unit: predict_pc and count are consumed there; flush_in is fed back from it.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 17 +
 rtl/branch_predictor.sv | 87 ++++++++
 tb/tb_branch_predictor.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: opcode groups, 2-bit counter encodings
// and the flush-suppression window states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] COUNT_MAX = 2'd2;

  typedef enum logic [1:0] {
    CNT_0 = 2'd0,
    CNT_1 = 2'd1,
    CNT_2 = 2'd2
  } count_state_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/EX-side signals of the branch predictor; the pipeline is master,
// the predictor is slave.
interface branch_predictor_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] predict_pc;
  logic            predict_taken;
  logic            update_en;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            flush_in;
  logic [1:0]      count;

  modport master (
    output fetch_pc, update_en, update_pc, update_taken, update_target, flush_in,
    input  predict_pc, predict_taken, count
  );

  modport slave (
    input  fetch_pc, update_en, update_pc, update_taken, update_target, flush_in,
    output predict_pc, predict_taken, count
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
  import riscv_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, plus the post-reset/post-flush
// count window consumed by the flush unit.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 32 - IDX_W - 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  count_state_t count_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] ftag;
  logic             hit;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic [1:0]       ctr_nxt;
  logic             unused_pc_bits;

  assign idx  = bus.fetch_pc[IDX_W+1:2];
  assign ftag = bus.fetch_pc[XLEN-1:IDX_W+2];
  assign uidx = bus.update_pc[IDX_W+1:2];
  assign utag = bus.update_pc[XLEN-1:IDX_W+2];

  // Low PC bits are ignored; word alignment is the ISA's guarantee.
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

  always_comb begin
    hit               = valid_q[idx] && (tag_q[idx] == ftag);
    bus.predict_taken = hit && ctr_q[idx][1];
    bus.predict_pc    = bus.predict_taken ? target_q[idx] : bus.fetch_pc + 32'd4;
  end

  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  sat_counter2 u_ctr (
    .ctr (ctr_q[uidx]),
    .up  (bus.update_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
      count_q <= CNT_0;
    end else begin
      if (bus.update_en) begin
        if (uhit) begin
          ctr_q[uidx] <= ctr_nxt;
          if (bus.update_taken) target_q[uidx] <= bus.update_target;
        end else if (bus.update_taken) begin
          valid_q[uidx]  <= 1'b1;
          tag_q[uidx]    <= utag;
          target_q[uidx] <= bus.update_target;
          ctr_q[uidx]    <= WT;
        end
      end

      if (bus.flush_in) begin
        count_q <= CNT_0;
      end else begin
        case (count_q)
          CNT_0:   count_q <= CNT_1;
          CNT_1:   count_q <= CNT_2;
          default: count_q <= CNT_2;
        endcase
      end
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  branch_predictor_if bp_if ();

  branch_predictor #(
    .ENTRIES (16),
    .IDX_W   (4),
    .TAG_W   (26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bp_if.update_en     = 1'b1;
    bp_if.update_pc     = pc;
    bp_if.update_taken  = tk;
    bp_if.update_target = tgt;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] pc,
                           input logic [31:0] exp_pc, input logic exp_tk);
    bp_if.fetch_pc = pc;
    #1;
    check({name, "_pc"}, bp_if.predict_pc, exp_pc);
    check({name, "_tk"}, {31'b0, bp_if.predict_taken}, {31'b0, exp_tk});
  endtask

  task automatic count_chk(input string name, input logic [1:0] exp);
    check(name, {30'b0, bp_if.count}, {30'b0, exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bp_if.fetch_pc      = 32'h0000_0100;
    bp_if.update_en     = 1'b0;
    bp_if.update_pc     = '0;
    bp_if.update_taken  = 1'b0;
    bp_if.update_target = '0;
    bp_if.flush_in      = 1'b0;
    tick();
    tick();

    // Reset state and the count window ramp
    fetch_chk("rst_fetch", 32'h0000_0100, 32'h0000_0104, 1'b0);
    rst = 1'b0;
    count_chk("count_c0", 2'd0);
    tick(); count_chk("count_c1", 2'd1);
    tick(); count_chk("count_c2", 2'd2);
    tick(); count_chk("count_c3", 2'd2);

    // First taken update allocates with ctr=WT
    upd(32'h40, 1'b1, 32'h80);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("alloc", 32'h40, 32'h80, 1'b1);

    // Two not-taken: 10 -> 01 -> 00
    upd(32'h40, 1'b0, 32'h0);
    tick();
    fetch_chk("nt1", 32'h40, 32'h44, 1'b0);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("nt2", 32'h40, 32'h44, 1'b0);

    // Four taken saturate at 11; one not-taken still predicts taken
    upd(32'h40, 1'b1, 32'h80);
    tick(); tick(); tick(); tick();
    upd(32'h40, 1'b0, 32'h0);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("sat", 32'h40, 32'h80, 1'b1);

    // One more not-taken drops 10 -> 01: now predicts fall-through
    upd(32'h40, 1'b0, 32'h0);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("sat_nt2", 32'h40, 32'h44, 1'b0);

    // Aliasing: 0x440 shares index 0 with 0x40
    upd(32'h40, 1'b1, 32'h80);
    tick();
    upd(32'h440, 1'b1, 32'h200);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("alias_old", 32'h40, 32'h44, 1'b0);
    fetch_chk("alias_new", 32'h440, 32'h200, 1'b1);

    // Same-cycle read and write: lookup sees pre-edge contents
    upd(32'h60, 1'b1, 32'h300);
    fetch_chk("rdw_pre", 32'h60, 32'h64, 1'b0);
    tick();
    bp_if.update_en = 1'b0;
    fetch_chk("rdw_post", 32'h60, 32'h300, 1'b1);

    // Back-to-back flushes
    count_chk("fl_pre", 2'd2);
    bp_if.flush_in = 1'b1;
    tick(); count_chk("fl_0a", 2'd0);
    tick(); count_chk("fl_0b", 2'd0);
    bp_if.flush_in = 1'b0;
    tick(); count_chk("fl_1", 2'd1);
    tick(); count_chk("fl_2", 2'd2);

    // Update and flush together: both take effect
    upd(32'h80, 1'b1, 32'h400);
    bp_if.flush_in = 1'b1;
    tick();
    bp_if.update_en = 1'b0;
    bp_if.flush_in  = 1'b0;
    count_chk("uf_count", 2'd0);
    fetch_chk("uf_train", 32'h80, 32'h400, 1'b1);

    // Reset concurrent with update: update discarded, table cleared
    tick();
    upd(32'hC0, 1'b1, 32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bp_if.update_en = 1'b0;
    count_chk("rstu_count", 2'd0);
    fetch_chk("rstu_alloc", 32'hC0, 32'hC4, 1'b0);
    fetch_chk("rstu_clear", 32'h440, 32'h444, 1'b0);

    // +4 wraps modulo 2^32
    fetch_chk("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
